washer_controller: RTL and testbench
====================================

WASHER_CONTROLLER -- requirements
Module: washer_controller

Interface
REQ-001 SHALL have parameter FILL_UNITS, default 2: FILL phase length in cnt_done pulses (1..255).
REQ-002 SHALL have parameter WASH_UNITS, default 3: WASH phase length in cnt_done pulses (1..255).
REQ-003 SHALL have parameter RINSE_UNITS, default 2: RINSE phase length in cnt_done pulses (1..255).
REQ-004 SHALL have parameter SPIN_UNITS, default 1: SPIN phase length in cnt_done pulses (1..255).
REQ-005 SHALL have ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- start_btn  input  1  cycle request, level-sampled.
- door_closed  input  1  door sensor, 1 = closed.
- pause  input  1  user pause, level.
- cnt_done  input  1  terminal pulse from the downstream unit-timer counter.
- cnt_start  output  1  enable to the unit-timer counter.
- water_valve  output  1  fill valve on.
- motor_on  output  1  drum motor on.
- motor_fast  output  1  spin speed select.
- drain_pump  output  1  drain pump on.
- door_lock  output  1  door lock engaged.
- busy  output  1  cycle in progress.
- cycle_done  output  1  one-cycle completion pulse.
- phase  output  3  current state encoding.
REQ-006 SHALL use only clk as clock; all state updates on its rising edge; rst is synchronous and active-high.

Function
REQ-007 SHALL implement states IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, COMPLETE=5; phase SHALL equal the current state code.
REQ-008 IDLE: start_btn=1 and door_closed=1 at an edge -> FILL next cycle; otherwise remain in IDLE.
REQ-009 Timed states are FILL, WASH, RINSE and SPIN; hold = pause | !door_closed.
REQ-010 cnt_start SHALL be 1 exactly when the state is timed and hold=0 (combinational decode of state, pause and door_closed).
REQ-011 An 8-bit unit counter SHALL increment on each edge where cnt_start=1 and cnt_done=1; cnt_done SHALL be ignored at every other time.
REQ-012 When cnt_done is accepted and unit counter = N-1 for the current phase's N, the FSM SHALL advance FILL->WASH->RINSE->SPIN->COMPLETE and clear the unit counter to 0.
REQ-013 During hold, state and unit counter SHALL freeze; water_valve, motor_on, motor_fast and drain_pump SHALL be 0; door_lock SHALL stay 1.
REQ-014 Actuators when not held: FILL: water_valve. WASH: motor_on. RINSE: water_valve and motor_on. SPIN: motor_on, motor_fast and drain_pump. All other states: all 0.
REQ-015 door_lock and busy SHALL be 1 in FILL through SPIN and 0 in IDLE and COMPLETE.
REQ-016 COMPLETE SHALL last exactly one cycle with cycle_done=1, then go to IDLE unconditionally; start_btn SHALL be ignored in COMPLETE.
REQ-017 start_btn SHALL be ignored in every state except IDLE; re-triggering a cycle requires a return to IDLE.
REQ-018 cnt_start SHALL stay continuously high across a phase advance, so the counter's self-clearing pulse is not double-counted.
REQ-019 No other state encoding is legal; an illegal encoding SHALL go to IDLE on the next edge.

Reset
REQ-020 rst=1 at an edge SHALL force state IDLE and unit counter 0; all outputs SHALL be 0 and phase=0 from the next cycle.
REQ-021 rst SHALL take priority over every other input, including mid-phase and during hold.

Verification
REQ-022 Bench SHALL pair the block with a COUNT_MAX=5 counter model and default parameters, and cover:
- rst then start_btn=1, door_closed=1, no hold -> FILL for 10 cycles, WASH 15, RINSE 10, SPIN 5, one COMPLETE cycle with cycle_done=1, then IDLE.
- start_btn=1, door_closed=0 in IDLE -> stays IDLE; busy=0, cnt_start=0.
- pause=1 for 7 cycles in WASH -> phase=2 held, cnt_start=0, motor_on=0, door_lock=1; WASH ends 7 cycles later than nominal.
- door_closed=0 for 3 cycles during SPIN -> all actuators 0, door_lock=1; SPIN resumes on close.
- rst=1 mid-RINSE -> next cycle phase=0, all outputs 0; new start gives full 10-cycle FILL.
- start_btn held high through the whole cycle -> exactly one cycle_done pulse, then immediate FILL restart after IDLE.

Source files
------------

// File: rtl/washer_controller.sv
// Washing-machine cycle controller.
//
// Drives one wash cycle: IDLE -> FILL -> WASH -> RINSE -> SPIN -> COMPLETE -> IDLE.
// Phase length is measured in pulses of an external unit-timer counter.
// cnt_start enables that counter and cnt_done is its terminal pulse.
// Each timed phase lasts <PHASE>_UNITS accepted cnt_done pulses. A pause, or an
// open door, freezes the cycle. While frozen, the actuators are off and the door
// stays locked.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start_btn    cycle request, honoured only in IDLE with the door closed
//   door_closed  door sensor, 1 = closed
//   pause        user pause, level
//   cnt_done     terminal pulse from the unit-timer counter
//   cnt_start    unit-timer enable (timed phase and not held)
//   water_valve  fill valve
//   motor_on     drum motor
//   motor_fast   spin speed select
//   drain_pump   drain pump
//   door_lock    door lock, engaged FILL..SPIN
//   busy         cycle in progress, FILL..SPIN
//   cycle_done   single-cycle pulse in COMPLETE
//   phase        current state code
module washer_controller #(
  parameter int FILL_UNITS  = 2,
  parameter int WASH_UNITS  = 3,
  parameter int RINSE_UNITS = 2,
  parameter int SPIN_UNITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       door_closed,
  input  logic       pause,
  input  logic       cnt_done,
  output logic       cnt_start,
  output logic       water_valve,
  output logic       motor_on,
  output logic       motor_fast,
  output logic       drain_pump,
  output logic       door_lock,
  output logic       busy,
  output logic       cycle_done,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    WASH     = 3'd2,
    RINSE    = 3'd3,
    SPIN     = 3'd4,
    COMPLETE = 3'd5
  } state_t;

  // Unit-counter value on which the final pulse of each phase is accepted.
  localparam logic [7:0] FILL_LAST  = 8'(FILL_UNITS  - 1);
  localparam logic [7:0] WASH_LAST  = 8'(WASH_UNITS  - 1);
  localparam logic [7:0] RINSE_LAST = 8'(RINSE_UNITS - 1);
  localparam logic [7:0] SPIN_LAST  = 8'(SPIN_UNITS  - 1);

  state_t     state, state_nxt;
  logic [7:0] unit_cnt, unit_cnt_nxt;
  logic [7:0] last_unit;
  logic       timed;
  logic       hold;
  logic       accept;

  assign timed  = (state == FILL) || (state == WASH) ||
                  (state == RINSE) || (state == SPIN);
  assign hold   = pause || !door_closed;
  assign accept = cnt_start && cnt_done;

  always_comb begin
    last_unit = 8'd0;
    case (state)
      FILL:    last_unit = FILL_LAST;
      WASH:    last_unit = WASH_LAST;
      RINSE:   last_unit = RINSE_LAST;
      SPIN:    last_unit = SPIN_LAST;
      default: last_unit = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      unit_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      unit_cnt <= unit_cnt_nxt;
    end
  end

  // Next state. The unit counter moves only on an accepted pulse.
  // An accepted pulse is never seen while held, so the hold freeze needs no
  // separate branch.
  always_comb begin
    state_nxt    = state;
    unit_cnt_nxt = unit_cnt;
    case (state)
      IDLE: begin
        unit_cnt_nxt = 8'd0;
        if (start_btn && door_closed) state_nxt = FILL;
      end
      FILL, WASH, RINSE, SPIN: begin
        if (accept) begin
          if (unit_cnt == last_unit) begin
            unit_cnt_nxt = 8'd0;
            case (state)
              FILL:    state_nxt = WASH;
              WASH:    state_nxt = RINSE;
              RINSE:   state_nxt = SPIN;
              default: state_nxt = COMPLETE;
            endcase
          end else begin
            unit_cnt_nxt = unit_cnt + 8'd1;
          end
        end
      end
      COMPLETE: begin
        state_nxt    = IDLE;
        unit_cnt_nxt = 8'd0;
      end
      default: begin
        state_nxt    = IDLE;
        unit_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Output decode is purely from state and the hold inputs.
  // cnt_start therefore stays high across a phase advance, because both phases
  // are timed. The counter's self-clearing pulse is seen exactly once.
  always_comb begin
    cnt_start   = timed && !hold;
    water_valve = 1'b0;
    motor_on    = 1'b0;
    motor_fast  = 1'b0;
    drain_pump  = 1'b0;
    door_lock   = timed;
    busy        = timed;
    cycle_done  = (state == COMPLETE);
    if (!hold) begin
      case (state)
        FILL: water_valve = 1'b1;
        WASH: motor_on = 1'b1;
        RINSE: begin
          water_valve = 1'b1;
          motor_on    = 1'b1;
        end
        SPIN: begin
          motor_on   = 1'b1;
          motor_fast = 1'b1;
          drain_pump = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_washer_controller.sv
module tb_washer_controller;

  logic       clk = 1'b0;
  logic       rst, start_btn, door_closed, pause, cnt_done;
  logic       cnt_start, water_valve, motor_on, motor_fast, drain_pump;
  logic       door_lock, busy, cycle_done;
  logic [2:0] phase;

  always #5 clk = ~clk;

  washer_controller dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .door_closed(door_closed),
    .pause(pause), .cnt_done(cnt_done), .cnt_start(cnt_start),
    .water_valve(water_valve), .motor_on(motor_on), .motor_fast(motor_fast),
    .drain_pump(drain_pump), .door_lock(door_lock), .busy(busy),
    .cycle_done(cycle_done), .phase(phase)
  );

  int checks = 0;
  int errors = 0;

  // Unit-timer counter with COUNT_MAX = 5. It pulses at count 4, self-clears,
  // and freezes while disabled. rand_mode instead feeds arbitrary pulses.
  logic [2:0] tcnt;
  logic       rand_mode, rand_done;
  always @(posedge clk) begin
    if (rst) tcnt <= 3'd0;
    else if (cnt_start) tcnt <= (tcnt == 3'd4) ? 3'd0 : tcnt + 3'd1;
  end
  assign cnt_done = rand_mode ? rand_done : (tcnt == 3'd4);

  // Behavioural model: phase index plus count of accepted pulses in the phase.
  int len [6] = '{0, 2, 3, 2, 1, 0};
  int m_ph, m_u;
  always @(posedge clk) begin
    if (rst) begin
      m_ph <= 0;
      m_u  <= 0;
    end else if (m_ph == 0) begin
      if (start_btn && door_closed) m_ph <= 1;
    end else if (m_ph == 5) begin
      m_ph <= 0;
    end else if (!pause && door_closed && cnt_done) begin
      if (m_u + 1 == len[m_ph]) begin
        m_ph <= m_ph + 1;
        m_u  <= 0;
      end else begin
        m_u <= m_u + 1;
      end
    end
  end

  // {cnt_start, valve, motor, fast, drain, door_lock, busy, cycle_done, phase}
  function automatic logic [10:0] expect_out(int ph, logic p, logic d);
    logic [3:0] acts [6];
    logic timed, run;
    acts  = '{4'b0000, 4'b1000, 4'b0100, 4'b1100, 4'b0111, 4'b0000};
    timed = (ph >= 1) && (ph <= 4);
    run   = timed && !(p || !d);
    return {run, run ? acts[ph] : 4'b0000, timed, timed, ph == 5, 3'(ph)};
  endfunction

  logic [10:0] outs;
  assign outs = {cnt_start, water_valve, motor_on, motor_fast, drain_pump,
                 door_lock, busy, cycle_done, phase};

  logic check_en = 1'b0;
  always @(negedge clk) begin
    if (check_en) begin
      logic [10:0] e;
      e = expect_out(m_ph, pause, door_closed);
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got %b expected %b", $time, outs, e);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Count negedge samples per phase until the cycle returns to IDLE after COMPLETE.
  int dur [6];
  int cd_pulses;
  task automatic measure();
    int n;
    n = 0;
    cd_pulses = 0;
    for (int i = 0; i < 6; i++) dur[i] = 0;
    forever begin
      @(negedge clk);
      n++;
      if (phase <= 3'd5) dur[phase]++;
      if (cycle_done) cd_pulses++;
      if (dur[5] > 0 && phase == 3'd0) break;
      if (n > 300) begin
        chk("measure_timeout", n, 0);
        break;
      end
    end
  endtask

  task automatic wait_phase(input logic [2:0] p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (phase != p && n < 300);
    if (phase != p) chk("wait_phase_timeout", int'(phase), int'(p));
  endtask

  task automatic press_start();
    @(posedge clk); #1 start_btn = 1'b1;
    @(posedge clk); #1 start_btn = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_btn = 1'b0; door_closed = 1'b1; pause = 1'b0;
    rand_mode = 1'b0; rand_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_en = 1'b1;
    @(negedge clk);
    chk("reset_outputs", int'(outs), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Nominal cycle
    press_start();
    measure();
    chk("nom_fill", dur[1], 10);
    chk("nom_wash", dur[2], 15);
    chk("nom_rinse", dur[3], 10);
    chk("nom_spin", dur[4], 5);
    chk("nom_complete", dur[5], 1);
    chk("nom_cycle_done", cd_pulses, 1);

    // Start with the door open is refused
    @(posedge clk); #1 door_closed = 1'b0; start_btn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("door_open_phase", int'(phase), 0);
      chk("door_open_busy", int'(busy), 0);
      chk("door_open_cnt_start", int'(cnt_start), 0);
    end
    @(posedge clk); #1 door_closed = 1'b1; start_btn = 1'b0;

    // Pause for 7 cycles in WASH
    press_start();
    fork
      measure();
      begin
        wait_phase(3'd2);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 pause = 1'b1;
        repeat (7) begin
          @(negedge clk);
          chk("pause_phase", int'(phase), 2);
          chk("pause_held_bits", int'({cnt_start, motor_on, door_lock}), 1);
          @(posedge clk);
        end
        #1 pause = 1'b0;
      end
    join
    chk("pause_fill", dur[1], 10);
    chk("pause_wash", dur[2], 22);
    chk("pause_rinse", dur[3], 10);

    // Door opened for 3 cycles during SPIN
    press_start();
    fork
      measure();
      begin
        wait_phase(3'd4);
        @(posedge clk); #1 door_closed = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("door_spin_bits", int'({water_valve, motor_on, motor_fast, drain_pump, door_lock}), 1);
          @(posedge clk);
        end
        #1 door_closed = 1'b1;
      end
    join
    chk("door_spin_len", dur[4], 8);
    chk("door_spin_done", cd_pulses, 1);

    // Reset mid-RINSE, then a fresh full cycle
    press_start();
    wait_phase(3'd3);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rinse_outputs", int'(outs), 0);
    press_start();
    measure();
    chk("after_rst_fill", dur[1], 10);
    chk("after_rst_wash", dur[2], 15);

    // start_btn held through the whole cycle
    @(posedge clk); #1 start_btn = 1'b1;
    measure();
    chk("held_cycle_done", cd_pulses, 1);
    chk("held_complete", dur[5], 1);
    chk("held_spin", dur[4], 5);
    @(negedge clk);
    chk("held_restart", int'(phase), 1);
    @(posedge clk); #1 start_btn = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Randomised stimulus against the model
    rand_mode = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      rst         = ($urandom_range(0, 149) == 0);
      start_btn   = ($urandom_range(0, 3) == 0);
      pause       = ($urandom_range(0, 7) == 0);
      door_closed = ($urandom_range(0, 9) != 0);
      rand_done   = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
